axi_stream_pkt_master: RTL

Source-side AXI4-Stream master. It sits directly upstream of the team's AXI-Stream packet receiver and feeds it.
- Takes one command per packet: word count and seed value.
- Emits a packet of incrementing data words, with tlast on the final beat.
- Packet length is capped at 8 words, so a packet always fits the receiver's 8-entry buffer.

---
 rtl/axi_stream_pkt_master.sv | 107 ++++++++++
 1 files changed

// File: rtl/axi_stream_pkt_master.sv
// AXI4-Stream packet source: one command (length, seed) produces a burst of incrementing words ending in tlast.
// Optional statistics counters are enabled by defining AXIS_PKT_MASTER_STATS_EN.
module axi_stream_pkt_master #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LEN    = 8
) (
    input  logic                       aclk,
    input  logic                       areset_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [$clog2(MAX_LEN)-1:0] cmd_len,
    input  logic [DATA_WIDTH-1:0]      cmd_seed,
    output logic                       busy,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [DATA_WIDTH-1:0]      m_tdata,
    output logic                       m_tlast
`ifdef AXIS_PKT_MASTER_STATS_EN
    ,
    output logic [15:0]                pkt_count,
    output logic [15:0]                stall_count
`endif
);

    localparam int LEN_W = $clog2(MAX_LEN);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [LEN_W-1:0]   beat_cnt;
    logic [LEN_W-1:0]   len_reg;
    logic               cmd_fire;
    logic               beat_fire;
    logic               last_fire;

    // cmd_ready decodes registered state only, so it never depends on m_tready.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state == SEND);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign beat_fire = m_tvalid && m_tready;
    assign last_fire = beat_fire && m_tlast;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_fire)  state_next = SEND;
            SEND:    if (last_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Beat registers advance only on a handshake, so a stalled beat holds its data and tlast.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            beat_cnt <= '0;
            len_reg  <= '0;
        end else if (cmd_fire) begin
            m_tvalid <= 1'b1;
            m_tdata  <= cmd_seed;
            m_tlast  <= (cmd_len == '0);
            beat_cnt <= '0;
            len_reg  <= cmd_len;
        end else if (last_fire) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            beat_cnt <= '0;
            len_reg  <= '0;
        end else if (beat_fire) begin
            m_tdata  <= m_tdata + DATA_WIDTH'(1);
            beat_cnt <= beat_cnt + LEN_W'(1);
            m_tlast  <= ((beat_cnt + LEN_W'(1)) == len_reg);
        end
    end

`ifdef AXIS_PKT_MASTER_STATS_EN
    // Packet count wraps; stall count saturates so a long stall cannot alias to a small number.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            pkt_count   <= '0;
            stall_count <= '0;
        end else begin
            if (last_fire) begin
                pkt_count <= pkt_count + 16'd1;
            end
            if (m_tvalid && !m_tready && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule
